tmds_rx_channel: RTL and testbench

Single-channel TMDS receiver for the ULX3S video path, the receive counterpart of the per-colour transmit channel. It takes the serial bit stream of one TMDS lane sampled at the bit clock, finds 10-bit word alignment from control tokens sent during blanking, and decodes each word back into 8-bit pixel data or the (c0, c1) control pair. Three instances, one per lane, feed the capture/sink side of the design.

---
 rtl/tmds_pkg.sv | 27 ++
 rtl/tmds_decode.sv | 25 ++
 rtl/tmds_rx_channel.sv | 135 +++++++++++++
 tb/tb_tmds_rx_channel.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive lane: control tokens, FSM states
// and the token lookup used by the decoder.
package tmds_pkg;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } rx_state_e;

    // Returns {hit, c1, c0}; c1/c0 are zero when the word is not a token.
    function automatic logic [2:0] tok_match(input logic [9:0] q);
        case (q)
            TOK_00:  return 3'b100;
            TOK_01:  return 3'b101;
            TOK_10:  return 3'b110;
            TOK_11:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/tmds_decode.sv
// Combinational 10b -> 8b TMDS word decoder with control-token detection.
module tmds_decode
    import tmds_pkg::*;
(
    input  logic [9:0] q,
    output logic [7:0] data,
    output logic       is_token,
    output logic       c0,
    output logic       c1
);

    logic [7:0] d;

    always_comb begin
        d       = q[7:0] ^ {8{q[9]}};
        data    = '0;
        data[0] = d[0];
        // q[8] selects whether the encoder chained bits with XOR or XNOR
        for (int i = 1; i < 8; i++) begin
            data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        {is_token, c1, c0} = tok_match(q);
    end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive lane: serial capture, word alignment on control tokens,
// lock supervision and registered decode outputs.
module tmds_rx_channel
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int MAX_ACTIVE = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] dout,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic       valid,
    output logic       locked
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int ACT_W = $clog2(MAX_ACTIVE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_COUNT - 1);
    localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(MAX_ACTIVE - 1);

    logic [9:0]       sr;
    logic [3:0]       ph;
    rx_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [ACT_W-1:0] act, act_nx;
    logic             ph_zero;
    logic             emit;
    logic             boundary;

    logic [7:0] dec_data;
    logic       dec_tok, dec_c0, dec_c1;

    tmds_decode u_dec (
        .q        (sr),
        .data     (dec_data),
        .is_token (dec_tok),
        .c0       (dec_c0),
        .c1       (dec_c1)
    );

    assign boundary = (ph == 4'd9);
    assign locked   = (state == LOCKED);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        act_nx   = act;
        ph_zero  = 1'b0;
        emit     = 1'b0;
        case (state)
            HUNT: begin
                // Sliding search: restart the phase so the next boundary is one word later
                if (dec_tok) begin
                    ph_zero  = 1'b1;
                    cnt_nx   = CNT_W'(1);
                    act_nx   = '0;
                    state_nx = VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (dec_tok) begin
                        act_nx = '0;
                        cnt_nx = cnt + 1'b1;
                        if (cnt == CNT_LAST) state_nx = LOCKED;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (dec_tok) begin
                        act_nx = '0;
                        emit   = 1'b1;
                    end else if (act == ACT_LAST) begin
                        // Too long without blanking: assume alignment is gone
                        act_nx   = act + 1'b1;
                        cnt_nx   = '0;
                        state_nx = HUNT;
                    end else begin
                        act_nx = act + 1'b1;
                        emit   = 1'b1;
                    end
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr    <= '0;
            ph    <= '0;
            state <= HUNT;
            cnt   <= '0;
            act   <= '0;
        end else begin
            sr    <= {din, sr[9:1]};
            ph    <= (ph_zero || boundary) ? 4'd0 : ph + 4'd1;
            state <= state_nx;
            cnt   <= cnt_nx;
            act   <= act_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout  <= '0;
            de    <= 1'b0;
            c0    <= 1'b0;
            c1    <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= emit;
            if (emit) begin
                // Tokens leave the last pixel byte in place
                if (dec_tok) begin
                    de <= 1'b0;
                    c0 <= dec_c0;
                    c1 <= dec_c1;
                end else begin
                    de   <= 1'b1;
                    dout <= dec_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Bench for tmds_rx_channel: serial word driver, reference TMDS encoder and
// a queue of expected decoded words checked on every valid strobe.
module tb_tmds_rx_channel;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic [7:0] dout;
    logic       de, c0, c1, valid, locked;

    tmds_rx_channel #(.LOCK_COUNT(8), .MAX_ACTIVE(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .dout   (dout),
        .de     (de),
        .c0     (c0),
        .c1     (c1),
        .valid  (valid),
        .locked (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] dout;
        logic       de;
        logic       c0;
        logic       c1;
        logic       cad;
    } exp_t;

    typedef struct {
        logic [9:0] q;
        logic [7:0] dout;
        logic       de;
        logic       c0;
        logic       c1;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[8];
    int   errors = 0, checks = 0, cyc = 0, last_vcyc = -1, cad_cnt = 0;
    logic [7:0] hdout;
    logic       hc0, hc1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference DVI encoder (transition-minimising stage plus optional inversion)
    function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic inv);
        int         ones;
        logic       xn;
        logic [8:0] qm;
        ones  = $countones(d);
        xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    function automatic logic [9:0] tok(input logic [1:0] cc);
        case (cc)
            2'b00:   return T00;
            2'b01:   return T01;
            2'b10:   return T10;
            default: return T11;
        endcase
    endfunction

    task automatic send_bit(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] q);
        for (int i = 0; i < 10; i++) send_bit(q[i]);
    endtask

    task automatic expect_word(input logic [7:0] d, input logic de_x, input logic c0_x,
                               input logic c1_x, input logic cad);
        sb.push_back({d, de_x, c0_x, c1_x, cad});
    endtask

    always @(negedge clk) begin
        cyc++;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("word{dout,de,c0,c1}", {dout, de, c0, c1}, {e.dout, e.de, e.c0, e.c1});
                if (e.cad) begin
                    cad_cnt++;
                    if (last_vcyc >= 0) check("valid_spacing", cyc - last_vcyc, 10);
                end
                last_vcyc = cyc;
            end
        end
    end

    initial begin
        logic [1:0] cc;
        logic [7:0] b;
        logic [9:0] q;

        tbl[0] = '{10'h100, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{10'h3FF, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{T11,     8'h00, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{10'h0FF, 8'hFF, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{T01,     8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{10'h201, 8'hFC, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{T10,     8'hFC, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{10'h155, 8'hFF, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_de", de, 0);
        check("rst_c0", c0, 0);
        check("rst_c1", c1, 0);
        check("rst_valid", valid, 0);
        check("rst_locked", locked, 0);
        rst = 1'b1;

        // Alignment behind three junk bits
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (8) send_word(T00);
        check("lock_not_yet", locked, 0);
        for (int i = 0; i < 4; i++) begin
            send_word(T00);
            expect_word(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 0) check("lock_after_8", locked, 1);
        end

        // Table-driven decode
        for (int i = 0; i < 8; i++) begin
            send_word(tbl[i].q);
            expect_word(tbl[i].dout, tbl[i].de, tbl[i].c0, tbl[i].c1, 1'b0);
        end
        hdout = tbl[7].dout; hc0 = tbl[7].c0; hc1 = tbl[7].c1;

        // Cadence: 100 locked words, tokens every eighth word
        for (int i = 0; i < 100; i++) begin
            if (i % 8 == 7) begin
                cc = 2'($urandom_range(0, 3));
                send_word(tok(cc));
                hc0 = cc[0]; hc1 = cc[1];
                expect_word(hdout, 1'b0, hc0, hc1, 1'b1);
            end else begin
                b = 8'($urandom_range(0, 255));
                q = tmds_enc(b, 1'($urandom_range(0, 1)));
                send_word(q);
                hdout = b;
                expect_word(b, 1'b1, hc0, hc1, 1'b1);
            end
        end
        send_word(T00);
        expect_word(hdout, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cadence_count", cad_cnt, 100);

        // Loss of lock after 16 data words
        for (int i = 0; i < 16; i++) begin
            send_word(10'h100);
            if (i < 15) expect_word(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("locked_before_drop", locked, 1);
        send_word(T00);
        check("lock_dropped", locked, 0);
        repeat (7) send_word(T00);
        check("relock_not_yet", locked, 0);
        send_word(T00);
        expect_word(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("relocked", locked, 1);

        // Reset in the middle of a word while locked
        send_word(tmds_enc(8'hA5, 1'b1));
        expect_word(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(T11);
        expect_word(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (6) send_bit(1'b0);
        rst = 1'b0;
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_de", de, 0);
        check("midrst_c0", c0, 0);
        check("midrst_c1", c1, 0);
        check("midrst_valid", valid, 0);
        check("midrst_locked", locked, 0);
        check("pending_before_rst", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) send_word(T00);
        check("postrst_not_yet", locked, 0);
        send_bit(1'b0);
        check("postrst_locked", locked, 1);

        // Failed verify: token followed by data at the next boundary
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_word(T00);
        send_word(10'h100);
        send_word(10'h100);
        check("verify_fail_unlocked", locked, 0);
        repeat (8) send_word(T00);
        check("verify_fail_not_yet", locked, 0);
        send_bit(1'b0);
        check("verify_fail_relock", locked, 1);

        repeat (3) @(posedge clk);
        check("all_expected_seen", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
